// File: rtl/riscv_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state encoding,
// machine word geometry and a small saturating-counter helper.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_WAIT = 2'd1,
        M_WAIT = 2'd2
    } arb_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
        logic [3:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch (F) and
// load/store (M); loads/stores win unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  F_req_i,
    input  logic [ADDR_W-1:0]     F_addr_i,
    output logic [DATA_W-1:0]     F_rdata_o,
    output logic                  F_valid_o,
    output logic                  F_busy_o,
    input  logic                  M_req_i,
    input  logic                  M_we_i,
    input  logic [ADDR_W-1:0]     M_addr_i,
    input  logic [DATA_W-1:0]     M_wdata_i,
    input  logic [DATA_W/8-1:0]   M_wmask_i,
    output logic [DATA_W-1:0]     M_rdata_o,
    output logic                  M_valid_o,
    output logic                  M_busy_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wmask_o,
    output logic                  mem_rstrb_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int         MASK_BITS  = DATA_W / 8;
    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [3:0]          lat_cnt_r;
    logic [3:0]          starve_cnt_r;
    logic                discard_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                grant_m_s;
    logic                grant_f_s;
    logic                done_s;
    logic                discard_now_s;

    assign done_s        = (state_r != IDLE) && (lat_cnt_r == 4'd0);
    // A flush arriving in the very completion cycle must still suppress the fetch.
    assign discard_now_s = discard_r | flush_i;
    assign F_busy_o      = F_req_i & ~F_valid_o;
    assign M_busy_o      = M_req_i & ~M_valid_o;

    // Grant decision, only made from IDLE and never while reset is held.
    always_comb begin
        grant_m_s = 1'b0;
        grant_f_s = 1'b0;
        if ((state_r == IDLE) && !rst_i) begin
            if (M_req_i && !(F_req_i && (starve_cnt_r == STARVE_LIM))) begin
                grant_m_s = 1'b1;
            end else if (F_req_i && !flush_i) begin
                grant_f_s = 1'b1;
            end else begin
                grant_m_s = 1'b0;
                grant_f_s = 1'b0;
            end
        end else begin
            grant_m_s = 1'b0;
            grant_f_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_m_s) begin
                    state_nxt_s = M_WAIT;
                end else if (grant_f_s) begin
                    state_nxt_s = F_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            F_WAIT, M_WAIT: begin
                if (lat_cnt_r == 4'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory port drive: live requester fields on the issue cycle, latched ones afterwards.
    always_comb begin
        mem_addr_o  = addr_r;
        mem_wdata_o = wdata_r;
        mem_wmask_o = {MASK_BITS{1'b0}};
        mem_rstrb_o = 1'b0;
        if (grant_m_s) begin
            mem_addr_o  = M_addr_i;
            mem_wdata_o = M_wdata_i;
            mem_wmask_o = M_we_i ? M_wmask_i : {MASK_BITS{1'b0}};
            mem_rstrb_o = ~M_we_i;
        end else if (grant_f_s) begin
            mem_addr_o  = F_addr_i;
            mem_rstrb_o = 1'b1;
        end else begin
            mem_rstrb_o = 1'b0;
        end
    end

    // Access sequencing: state, latency countdown, latched access context and discard flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            lat_cnt_r <= 4'd0;
            discard_r <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_m_s || grant_f_s) begin
                lat_cnt_r <= LAT_INIT;
                addr_r    <= mem_addr_o;
                wdata_r   <= mem_wdata_o;
                we_r      <= grant_m_s & M_we_i;
            end else if ((state_r != IDLE) && (lat_cnt_r != 4'd0)) begin
                lat_cnt_r <= lat_cnt_r - 4'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if (done_s) begin
                discard_r <= 1'b0;
            end else if ((state_r == F_WAIT) && flush_i) begin
                discard_r <= 1'b1;
            end else begin
                discard_r <= discard_r;
            end
        end
    end

    // Completion: capture read data and pulse the winner's valid for one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            F_valid_o <= 1'b0;
            M_valid_o <= 1'b0;
            F_rdata_o <= {DATA_W{1'b0}};
            M_rdata_o <= {DATA_W{1'b0}};
        end else begin
            F_valid_o <= 1'b0;
            M_valid_o <= 1'b0;
            if (done_s && (state_r == F_WAIT) && !discard_now_s) begin
                F_valid_o <= 1'b1;
                F_rdata_o <= mem_rdata_i;
            end else if (done_s && (state_r == M_WAIT)) begin
                M_valid_o <= 1'b1;
                if (!we_r) begin
                    M_rdata_o <= mem_rdata_i;
                end else begin
                    M_rdata_o <= M_rdata_o;
                end
            end else begin
                F_rdata_o <= F_rdata_o;
                M_rdata_o <= M_rdata_o;
            end
        end
    end

    // Fetch starvation counter: counts M wins over a waiting fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_f_s) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_m_s && F_req_i) begin
            starve_cnt_r <= sat_inc4(starve_cnt_r, STARVE_LIM);
        end else if ((state_r == IDLE) && !F_req_i) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3)
// share requester stimulus; each sees a combinational address-decoded memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        f_req;
    logic [31:0] f_addr;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;

    logic [31:0] f_rdata1, m_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        f_valid1, f_busy1, m_valid1, m_busy1, mem_rstrb1;
    logic [3:0]  mem_wmask1;
    logic [31:0] f_rdata3, m_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        f_valid3, f_busy3, m_valid3, m_busy3, mem_rstrb3;
    logic [3:0]  mem_wmask3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        logic [31:0] d;
        case (a)
            32'h0000_0100: d = 32'h0000_0013;
            32'h0000_0200: d = 32'h0000_0093;
            32'h0000_2000: d = 32'hDEAD_BEEF;
            default:       d = 32'hC0DE_0000 | {16'h0000, a[15:0]};
        endcase
        return d;
    endfunction

    assign mem_rdata1 = mem_model(mem_addr1);
    assign mem_rdata3 = mem_model(mem_addr3);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .F_req_i(f_req), .F_addr_i(f_addr), .F_rdata_o(f_rdata1), .F_valid_o(f_valid1), .F_busy_o(f_busy1),
        .M_req_i(m_req), .M_we_i(m_we), .M_addr_i(m_addr), .M_wdata_i(m_wdata), .M_wmask_i(m_wmask),
        .M_rdata_o(m_rdata1), .M_valid_o(m_valid1), .M_busy_o(m_busy1),
        .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_wmask_o(mem_wmask1),
        .mem_rstrb_o(mem_rstrb1), .mem_rdata_i(mem_rdata1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .F_req_i(f_req), .F_addr_i(f_addr), .F_rdata_o(f_rdata3), .F_valid_o(f_valid3), .F_busy_o(f_busy3),
        .M_req_i(m_req), .M_we_i(m_we), .M_addr_i(m_addr), .M_wdata_i(m_wdata), .M_wmask_i(m_wmask),
        .M_rdata_o(m_rdata3), .M_valid_o(m_valid3), .M_busy_o(m_busy3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_wmask_o(mem_wmask3),
        .mem_rstrb_o(mem_rstrb3), .mem_rdata_i(mem_rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        f_req = 1'b1; f_addr = 32'h100;
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0; m_wdata = 32'h0; m_wmask = 4'hF;

        // Reset state, with requests asserted to show issue strobes stay low
        tick(); tick();
        chk("rst_f_valid", {31'd0, f_valid1}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid1}, 32'd0);
        chk("rst_f_rdata", f_rdata1, 32'd0);
        chk("rst_m_rdata", m_rdata1, 32'd0);
        chk("rst_rstrb", {31'd0, mem_rstrb1}, 32'd0);
        chk("rst_wmask", {28'd0, mem_wmask1}, 32'd0);

        // 1: lone fetch
        m_req = 1'b0; m_we = 1'b0; m_wmask = 4'h0; rst = 1'b0;
        #1;
        chk("t1_issue_rstrb", {31'd0, mem_rstrb1}, 32'd1);
        chk("t1_issue_addr", mem_addr1, 32'h100);
        chk("t1_busy_issue", {31'd0, f_busy1}, 32'd1);
        tick();
        chk("t1_wait_valid", {31'd0, f_valid1}, 32'd0);
        chk("t1_wait_busy", {31'd0, f_busy1}, 32'd1);
        chk("t1_wait_rstrb", {31'd0, mem_rstrb1}, 32'd0);
        chk("t1_wait_addr", mem_addr1, 32'h100);
        tick();
        chk("t1_valid", {31'd0, f_valid1}, 32'd1);
        chk("t1_rdata", f_rdata1, 32'h0000_0013);
        chk("t1_busy_done", {31'd0, f_busy1}, 32'd0);
        f_req = 1'b0;
        tick();
        chk("t1_valid_pulse", {31'd0, f_valid1}, 32'd0);

        // 2: simultaneous F and M, M wins
        f_req = 1'b1; f_addr = 32'h104; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h2000;
        #1;
        chk("t2_m_first_addr", mem_addr1, 32'h2000);
        chk("t2_m_first_rstrb", {31'd0, mem_rstrb1}, 32'd1);
        tick();
        chk("t2_m_wait_valid", {31'd0, m_valid1}, 32'd0);
        chk("t2_f_busy", {31'd0, f_busy1}, 32'd1);
        tick();
        chk("t2_m_valid", {31'd0, m_valid1}, 32'd1);
        chk("t2_m_rdata", m_rdata1, 32'hDEAD_BEEF);
        chk("t2_m_busy_done", {31'd0, m_busy1}, 32'd0);
        m_req = 1'b0;
        #1;
        chk("t2_f_next_addr", mem_addr1, 32'h104);
        tick();
        chk("t2_m_valid_pulse", {31'd0, m_valid1}, 32'd0);
        chk("t2_f_not_yet", {31'd0, f_valid1}, 32'd0);
        tick();
        chk("t2_f_valid", {31'd0, f_valid1}, 32'd1);
        chk("t2_f_rdata", f_rdata1, 32'hC0DE_0104);
        f_req = 1'b0;
        tick();
        chk("t2_f_valid_pulse", {31'd0, f_valid1}, 32'd0);

        // 3: starvation limit, four M grants then F, then M resumes
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h3000; f_req = 1'b1; f_addr = 32'h108;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_grant%0d_addr", i), mem_addr1, (i < 4) ? 32'h3000 : 32'h108);
            chk($sformatf("t3_grant%0d_rstrb", i), {31'd0, mem_rstrb1}, 32'd1);
            tick(); tick();
        end
        chk("t3_f_valid", {31'd0, f_valid1}, 32'd1);
        chk("t3_f_rdata", f_rdata1, 32'hC0DE_0108);
        f_req = 1'b0;
        #1;
        chk("t3_m_resume_addr", mem_addr1, 32'h3000);
        chk("t3_m_resume_rstrb", {31'd0, mem_rstrb1}, 32'd1);
        tick(); tick();
        chk("t3_m_valid", {31'd0, m_valid1}, 32'd1);
        m_req = 1'b0;
        tick();

        // 5: store with partial byte mask
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h4000; m_wdata = 32'hAABB_CCDD; m_wmask = 4'b0011;
        #1;
        chk("t5_wmask_issue", {28'd0, mem_wmask1}, 32'h3);
        chk("t5_rstrb", {31'd0, mem_rstrb1}, 32'd0);
        chk("t5_wdata", mem_wdata1, 32'hAABB_CCDD);
        tick();
        chk("t5_wmask_after", {28'd0, mem_wmask1}, 32'd0);
        chk("t5_wdata_held", mem_wdata1, 32'hAABB_CCDD);
        chk("t5_valid_early", {31'd0, m_valid1}, 32'd0);
        tick();
        chk("t5_m_valid", {31'd0, m_valid1}, 32'd1);
        chk("t5_rdata_kept", m_rdata1, 32'hC0DE_3000);
        m_req = 1'b0; m_we = 1'b0; m_wmask = 4'h0;
        tick();

        // 6: reset during M_WAIT
        m_req = 1'b1; m_addr = 32'h2000;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_no_m_valid", {31'd0, m_valid1}, 32'd0);
        chk("t6_m_rdata_rst", m_rdata1, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_regrant_addr", mem_addr1, 32'h2000);
        chk("t6_regrant_rstrb", {31'd0, mem_rstrb1}, 32'd1);
        tick(); tick();
        chk("t6_m_valid", {31'd0, m_valid1}, 32'd1);
        chk("t6_m_rdata", m_rdata1, 32'hDEAD_BEEF);
        m_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 4: flush during F_WAIT on the MEM_LAT=3 instance
        f_req = 1'b1; f_addr = 32'h100;
        #1;
        chk("t4_issue_rstrb", {31'd0, mem_rstrb3}, 32'd1);
        tick();
        flush = 1'b1;
        chk("t4_busy", {31'd0, f_busy3}, 32'd1);
        tick();
        flush = 1'b0; f_addr = 32'h200;
        tick();
        chk("t4_addr_held", mem_addr3, 32'h100);
        tick();
        chk("t4_no_valid", {31'd0, f_valid3}, 32'd0);
        chk("t4_rdata_kept", f_rdata3, 32'd0);
        chk("t4_new_addr", mem_addr3, 32'h200);
        chk("t4_new_rstrb", {31'd0, mem_rstrb3}, 32'd1);
        tick(); tick(); tick();
        chk("t4_valid_not_early", {31'd0, f_valid3}, 32'd0);
        tick();
        chk("t4_valid", {31'd0, f_valid3}, 32'd1);
        chk("t4_rdata", f_rdata3, 32'h0000_0093);
        f_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
